priv_trap_ctrl: RTL and testbench

- Parametrised machine-mode trap sequencer for RISCVBusiness privilege blocks.
- Generalises the fixed-cause privilege control path to NUM_EXC exception sources and NUM_INT interrupt sources, adds vectored mtvec mode, and runs an explicit flush handshake with the pipeline.
- Owns mepc, mcause, mtval and mstatus.MIE/MPIE.
- Sits between the pipeline hazard unit and the CSR file; the CSR file reads its outputs and forwards software writes to it.

---
 rtl/priv_trap_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_priv_trap_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priv_trap_ctrl.sv
// priv_trap_ctrl: machine-mode trap sequencer.
// Picks the winning exception or interrupt, runs the flush handshake with the
// pipeline, then commits mepc/mcause/mtval/mstatus and redirects the PC.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | watching for events; software CSR writes accepted here
// FLUSH      | trap latched, trap_req held until the pipeline acks
// COMMIT     | insert_pc to the trap vector; trap CSRs update on exit
// RET_FLUSH  | mret latched, trap_req held until the pipeline acks
// RET_COMMIT | insert_pc to mepc; MIE/MPIE restored on exit
module priv_trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int NUM_EXC     = 16,
  parameter int NUM_INT     = 16,
  parameter bit VEC_MODE_EN = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_EXC-1:0] exc_vec,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic [NUM_INT-1:0] int_pend,
  input  logic [NUM_INT-1:0] int_en,
  input  logic [XLEN-1:0]    mtvec,
  input  logic               mret,
  input  logic               pipe_ack,
  input  logic               csr_wen,
  input  logic [1:0]         csr_waddr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic               trap_req,
  output logic               insert_pc,
  output logic [XLEN-1:0]    priv_pc,
  output logic               busy,
  output logic [XLEN-1:0]    mepc,
  output logic [XLEN-1:0]    mcause,
  output logic [XLEN-1:0]    mtval,
  output logic               mstatus_mie,
  output logic               mstatus_mpie
);

  localparam int MAXN = (NUM_EXC > NUM_INT) ? NUM_EXC : NUM_INT;
  localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

  typedef enum logic [2:0] {
    IDLE, FLUSH, COMMIT, RET_FLUSH, RET_COMMIT
  } state_t;

  state_t            r_state, w_next;
  logic              r_is_int, r_cause_int, r_mie, r_mpie;
  logic [CW-1:0]     r_code, r_cause_code;
  logic [XLEN-1:0]   r_pc, r_tval, r_mepc, r_mtval;
  logic              w_exc_hit, w_int_hit;
  logic [NUM_INT-1:0] w_int_act;
  logic [CW-1:0]     w_exc_code, w_int_code;
  logic [XLEN-1:0]   w_base, w_vec_off, w_target;

  assign w_int_act = int_pend & int_en;
  assign w_exc_hit = |exc_vec;
  assign w_int_hit = r_mie & (|w_int_act);

  // Lowest set exception index and highest enabled-pending interrupt index.
  always_comb begin
    w_exc_code = '0;
    w_int_code = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--)
      if (exc_vec[i]) w_exc_code = CW'(i);
    for (int j = 0; j < NUM_INT; j++)
      if (w_int_act[j]) w_int_code = CW'(j);
  end

  // Trap vector; modes 2/3 fall back to direct, vectored sum wraps naturally.
  assign w_base    = {mtvec[XLEN-1:2], 2'b00};
  assign w_vec_off = {{(XLEN-CW-2){1'b0}}, r_code, 2'b00};
  assign w_target  = (VEC_MODE_EN && (mtvec[1:0] == 2'b01) && r_is_int)
                     ? (w_base + w_vec_off) : w_base;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    trap_req  = 1'b0;
    insert_pc = 1'b0;
    priv_pc   = '0;
    busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_exc_hit || w_int_hit) w_next = FLUSH;
        else if (mret)              w_next = RET_FLUSH;
      end
      FLUSH: begin
        trap_req = 1'b1;
        if (pipe_ack) w_next = COMMIT;
      end
      COMMIT: begin
        insert_pc = 1'b1;
        priv_pc   = w_target;
        w_next    = IDLE;
      end
      RET_FLUSH: begin
        trap_req = 1'b1;
        if (pipe_ack) w_next = RET_COMMIT;
      end
      RET_COMMIT: begin
        insert_pc = 1'b1;
        priv_pc   = r_mepc;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Event capture, trap/return commit and software CSR writes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_is_int     <= 1'b0;
      r_code       <= '0;
      r_pc         <= '0;
      r_tval       <= '0;
      r_mepc       <= '0;
      r_mtval      <= '0;
      r_cause_int  <= 1'b0;
      r_cause_code <= '0;
      r_mie        <= 1'b0;
      r_mpie       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_exc_hit) begin
            r_is_int <= 1'b0;
            r_code   <= w_exc_code;
            r_pc     <= exc_pc;
            r_tval   <= exc_tval;
          end else if (w_int_hit) begin
            r_is_int <= 1'b1;
            r_code   <= w_int_code;
            r_pc     <= exc_pc;
            r_tval   <= '0;
          end else if (!mret && csr_wen) begin
            case (csr_waddr)
              2'd0: begin
                r_mie  <= csr_wdata[3];
                r_mpie <= csr_wdata[7];
              end
              2'd1: r_mepc <= csr_wdata & ~XLEN'(3);
              2'd2: begin
                r_cause_int  <= csr_wdata[XLEN-1];
                r_cause_code <= csr_wdata[CW-1:0];
              end
              default: r_mtval <= csr_wdata;
            endcase
          end
        end
        COMMIT: begin
          r_mepc       <= r_pc & ~XLEN'(3);
          r_cause_int  <= r_is_int;
          r_cause_code <= r_code;
          r_mtval      <= r_tval;
          r_mpie       <= r_mie;
          r_mie        <= 1'b0;
        end
        RET_COMMIT: begin
          r_mie  <= r_mpie;
          r_mpie <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mepc         = r_mepc;
  assign mcause       = {r_cause_int, {(XLEN-1-CW){1'b0}}, r_cause_code};
  assign mtval        = r_mtval;
  assign mstatus_mie  = r_mie;
  assign mstatus_mpie = r_mpie;

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Bench for priv_trap_ctrl: reset checks, a table of directed trap vectors,
// hand-written multi-cycle sequences and a randomized phase against a model.
module tb_priv_trap_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] exc_vec = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_tval = '0;
  logic [15:0] int_pend = '0;
  logic [15:0] int_en = '0;
  logic [31:0] mtvec = '0;
  logic        mret = 1'b0;
  logic        pipe_ack = 1'b0;
  logic        csr_wen = 1'b0;
  logic [1:0]  csr_waddr = '0;
  logic [31:0] csr_wdata = '0;
  logic        trap_req, insert_pc, busy, mstatus_mie, mstatus_mpie;
  logic [31:0] priv_pc, mepc, mcause, mtval;

  int n_checks = 0;
  int n_fail = 0;

  priv_trap_ctrl dut (
    .CLK(CLK), .RST(RST), .exc_vec(exc_vec), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .int_pend(int_pend), .int_en(int_en), .mtvec(mtvec), .mret(mret),
    .pipe_ack(pipe_ack), .csr_wen(csr_wen), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .trap_req(trap_req), .insert_pc(insert_pc),
    .priv_pc(priv_pc), .busy(busy), .mepc(mepc), .mcause(mcause), .mtval(mtval),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic csr_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge CLK);
    csr_wen = 1'b1; csr_waddr = addr; csr_wdata = data;
    @(negedge CLK);
    csr_wen = 1'b0;
  endtask

  // Present an event for one cycle, ack after ack_delay cycles of trap_req,
  // capture priv_pc at insert_pc and return one cycle after the commit.
  task automatic fire(input logic [15:0] ev, input logic [15:0] pend,
                      input logic [15:0] en, input logic [31:0] pc,
                      input logic [31:0] tval, input int ack_delay,
                      output logic [31:0] ppc, output int treq, output bit ok);
    ppc = '0; treq = 0; ok = 1'b0;
    @(negedge CLK);
    exc_vec = ev; int_pend = pend; int_en = en; exc_pc = pc; exc_tval = tval;
    pipe_ack = 1'b0;
    @(negedge CLK);
    exc_vec = '0; int_pend = '0;
    for (int c = 0; c < 40; c++) begin
      if (insert_pc) begin
        ppc = priv_pc;
        ok  = !trap_req;
        break;
      end
      if (trap_req) begin
        treq++;
        pipe_ack = (treq > ack_delay);
      end else pipe_ack = 1'b0;
      @(negedge CLK);
    end
    pipe_ack = 1'b0;
    @(negedge CLK);
  endtask

  // Reference model: trap outcome computed directly from the priority rules.
  function automatic int low_bit(input logic [31:0] x);
    logic [31:0] iso;
    iso = x & (~x + 32'd1);
    return $clog2(iso);
  endfunction

  function automatic int high_bit(input logic [31:0] x);
    return $clog2({1'b0, x} + 33'd1) - 1;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] tv, input bit is_int, input int code);
    logic [31:0] base;
    base = tv & ~32'd3;
    if (tv[1:0] == 2'b01 && is_int) return base + 32'(4 * code);
    return base;
  endfunction

  typedef struct {
    logic [31:0] tv;
    bit          mie0;
    logic [15:0] ev;
    logic [15:0] pend;
    logic [15:0] en;
    logic [31:0] pc;
    logic [31:0] tval;
    logic [31:0] exp_cause;
    logic [31:0] exp_ppc;
    logic [31:0] exp_mepc;
    logic [31:0] exp_tval;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [31:0] ppc;
    int treq, cnt;
    bit ok;

    vt[0] = '{32'h2001, 1'b0, 16'h8000, 16'h0000, 16'h0000, 32'h0000_0A07, 32'h1111, 32'h0000_000F, 32'h2000, 32'h0A04, 32'h1111};
    vt[1] = '{32'h2001, 1'b1, 16'h0000, 16'h0003, 16'h0002, 32'h0000_0B00, 32'h2222, 32'h8000_0001, 32'h2004, 32'h0B00, 32'h0};
    vt[2] = '{32'hFFFF_FFF1, 1'b1, 16'h0000, 16'h8000, 16'h8000, 32'h0000_0C01, 32'h3333, 32'h8000_000F, 32'h0000_002C, 32'h0C00, 32'h0};
    vt[3] = '{32'h3002, 1'b1, 16'h0000, 16'h0010, 16'hFFFF, 32'h0000_0D02, 32'h4444, 32'h8000_0004, 32'h3000, 32'h0D00, 32'h0};
    vt[4] = '{32'h3003, 1'b1, 16'h0000, 16'h0400, 16'hFFFF, 32'h0000_0E03, 32'h5555, 32'h8000_000A, 32'h3000, 32'h0E00, 32'h0};
    vt[5] = '{32'h4001, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'h0000_0F10, 32'h6666, 32'h0000_0000, 32'h4000, 32'h0F10, 32'h6666};
    vt[6] = '{32'h5001, 1'b1, 16'h0000, 16'h0001, 16'h0001, 32'h0000_1234, 32'h7777, 32'h8000_0000, 32'h5000, 32'h1234, 32'h0};

    // Reset state
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_trap_req", {31'b0, trap_req}, 32'd0);
    check("rst_insert_pc", {31'b0, insert_pc}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mie_mpie", {30'b0, mstatus_mie, mstatus_mpie}, 32'd0);
    check("rst_mepc", mepc, 32'd0);
    check("rst_mcause", mcause, 32'd0);
    check("rst_mtval", mtval, 32'd0);
    check("rst_priv_pc", priv_pc, 32'd0);

    // Reset in the middle of a flush
    exc_vec = 16'h0004; exc_pc = 32'h100;
    @(negedge CLK);
    exc_vec = '0;
    check("midrst_trap_req_before", {31'b0, trap_req}, 32'd1);
    #2 RST = 1'b1;
    #1;
    check("midrst_trap_req_drop", {31'b0, trap_req}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge CLK);
      if (insert_pc || trap_req) cnt++;
    end
    check("midrst_no_redirect", cnt, 0);
    check("midrst_mepc", mepc, 32'd0);

    // Exception path with late ack
    mtvec = 32'h1001;
    fire(16'h0024, 16'h0, 16'h0, 32'h203, 32'hDEAD, 2, ppc, treq, ok);
    check("exc_done", {31'b0, ok}, 32'd1);
    check("exc_treq_cycles", treq, 3);
    check("exc_priv_pc", ppc, 32'h1000);
    check("exc_mcause", mcause, 32'd2);
    check("exc_mepc", mepc, 32'h200);
    check("exc_mtval", mtval, 32'hDEAD);
    check("exc_mie", {31'b0, mstatus_mie}, 32'd0);

    // Vectored interrupt
    csr_write(2'd0, 32'h8);
    check("csr_mie_set", {31'b0, mstatus_mie}, 32'd1);
    fire(16'h0, 16'h0880, 16'hFFFF, 32'h404, 32'hBEEF, 0, ppc, treq, ok);
    check("vint_done", {31'b0, ok}, 32'd1);
    check("vint_priv_pc", ppc, 32'h102C);
    check("vint_mcause", mcause, 32'h8000_000B);
    check("vint_mtval", mtval, 32'd0);
    check("vint_mpie", {31'b0, mstatus_mpie}, 32'd1);
    check("vint_mie", {31'b0, mstatus_mie}, 32'd0);

    // mret back to mepc
    @(negedge CLK);
    mret = 1'b1;
    @(negedge CLK);
    mret = 1'b0;
    ok = 1'b0; ppc = '0;
    for (int c = 0; c < 20; c++) begin
      if (insert_pc) begin ppc = priv_pc; ok = 1'b1; break; end
      pipe_ack = trap_req;
      @(negedge CLK);
    end
    pipe_ack = 1'b0;
    @(negedge CLK);
    check("mret_done", {31'b0, ok}, 32'd1);
    check("mret_priv_pc", ppc, 32'h404);
    check("mret_mie_mpie", {30'b0, mstatus_mie, mstatus_mpie}, 32'd3);

    // Exception beats interrupt; exception stays direct under vectored mtvec
    fire(16'h0008, 16'h0080, 16'hFFFF, 32'h500, 32'h99, 0, ppc, treq, ok);
    check("conf_done", {31'b0, ok}, 32'd1);
    check("conf_mcause", mcause, 32'd3);
    check("conf_priv_pc", ppc, 32'h1000);

    // Masking by mie=0, then enabling via CSR write
    @(negedge CLK);
    int_pend = 16'h0001; int_en = 16'h0001;
    cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (trap_req) cnt++;
    end
    check("mask_no_trap", cnt, 0);
    csr_wen = 1'b1; csr_waddr = 2'd0; csr_wdata = 32'h8;
    @(negedge CLK);
    csr_wen = 1'b0;
    check("unmask_not_yet", {31'b0, trap_req}, 32'd0);
    @(negedge CLK);
    check("unmask_trap_2cyc", {31'b0, trap_req}, 32'd1);
    int_pend = '0;
    pipe_ack = 1'b1;
    @(negedge CLK);
    pipe_ack = 1'b0;
    check("unmask_insert", {31'b0, insert_pc}, 32'd1);
    @(negedge CLK);
    check("unmask_mcause", mcause, 32'h8000_0000);

    // CSR writes in IDLE and a dropped write while busy
    csr_write(2'd1, 32'h107);
    check("csr_mepc", mepc, 32'h104);
    csr_write(2'd2, 32'hFFFF_FFFF);
    check("csr_mcause", mcause, 32'h8000_000F);
    csr_write(2'd3, 32'hCAFE_0001);
    check("csr_mtval", mtval, 32'hCAFE_0001);
    @(negedge CLK);
    exc_vec = 16'h0002; exc_tval = 32'h77;
    @(negedge CLK);
    exc_vec = '0;
    csr_wen = 1'b1; csr_waddr = 2'd3; csr_wdata = 32'h1234;
    @(negedge CLK);
    csr_wen = 1'b0;
    check("busy_csr_dropped", mtval, 32'hCAFE_0001);
    check("busy_mepc_kept", mepc, 32'h104);
    pipe_ack = 1'b1;
    @(negedge CLK);
    pipe_ack = 1'b0;
    @(negedge CLK);
    check("busy_commit_tval", mtval, 32'h77);

    // Directed vector table
    for (int k = 0; k < 7; k++) begin
      mtvec = vt[k].tv;
      csr_write(2'd0, vt[k].mie0 ? 32'h8 : 32'h0);
      fire(vt[k].ev, vt[k].pend, vt[k].en, vt[k].pc, vt[k].tval, k % 3, ppc, treq, ok);
      check($sformatf("vec%0d_done", k), {31'b0, ok}, 32'd1);
      check($sformatf("vec%0d_priv_pc", k), ppc, vt[k].exp_ppc);
      check($sformatf("vec%0d_mcause", k), mcause, vt[k].exp_cause);
      check($sformatf("vec%0d_mepc", k), mepc, vt[k].exp_mepc);
      check($sformatf("vec%0d_mtval", k), mtval, vt[k].exp_tval);
      check($sformatf("vec%0d_mpie", k), {31'b0, mstatus_mpie}, {31'b0, vt[k].mie0});
    end

    // Randomized traps against the model
    for (int r = 0; r < 60; r++) begin
      logic [15:0] ev, pend, en;
      logic [31:0] pc, tval, tv, ecause, eppc;
      bit m_mie, m_mpie, hit, is_int;
      int code;
      ev     = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
      pend   = 16'($urandom);
      en     = 16'($urandom);
      pc     = $urandom;
      tval   = $urandom;
      tv     = $urandom;
      m_mie  = 1'($urandom);
      m_mpie = 1'($urandom);
      mtvec  = tv;
      csr_write(2'd0, {24'b0, m_mpie, 3'b0, m_mie, 3'b0});
      hit = (ev != 0) || (m_mie && ((pend & en) != 0));
      if (!hit) begin
        @(negedge CLK);
        exc_vec = ev; int_pend = pend; int_en = en;
        cnt = 0;
        repeat (3) begin
          @(negedge CLK);
          if (trap_req) cnt++;
        end
        int_pend = '0;
        check($sformatf("rnd%0d_no_trap", r), cnt, 0);
      end else begin
        is_int = (ev == 0);
        code   = is_int ? high_bit({16'b0, pend & en}) : low_bit({16'b0, ev});
        ecause = {is_int, 31'(code)};
        eppc   = model_target(tv, is_int, code);
        fire(ev, pend, en, pc, tval, $urandom_range(0, 3), ppc, treq, ok);
        check($sformatf("rnd%0d_done", r), {31'b0, ok}, 32'd1);
        check($sformatf("rnd%0d_priv_pc", r), ppc, eppc);
        check($sformatf("rnd%0d_mcause", r), mcause, ecause);
        check($sformatf("rnd%0d_mepc", r), mepc, pc & ~32'd3);
        check($sformatf("rnd%0d_mtval", r), mtval, is_int ? 32'd0 : tval);
        check($sformatf("rnd%0d_mstatus", r), {30'b0, mstatus_mie, mstatus_mpie}, {30'b0, 1'b0, m_mie});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
